// File: rtl/cpu_obi_port_arbiter.sv
// Shares one OBI slave port between the instruction and data master ports.
// A combinational arbiter picks a winner and forwards its request with no
// added latency. The selection is locked while the slave withholds gnt.
// A small ID FIFO remembers which master owns each granted transaction, so
// every rvalid/rdata is steered back to the right master in order.
module cpu_obi_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIO       = 1'b1,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // instruction master
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  input  logic                instr_we_i,
  input  logic [DATA_W/8-1:0] instr_be_i,
  input  logic [DATA_W-1:0]   instr_wdata_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  // data master
  input  logic                data_req_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  // shared slave
  output logic                slv_req_o,
  output logic [ADDR_W-1:0]   slv_addr_o,
  output logic                slv_we_o,
  output logic [DATA_W/8-1:0] slv_be_o,
  output logic [DATA_W-1:0]   slv_wdata_o,
  input  logic                slv_gnt_i,
  input  logic                slv_rvalid_i,
  input  logic [DATA_W-1:0]   slv_rdata_i,
  // status
  output logic [3:0]          outstanding_o,
  output logic                err_o
);

  localparam int              PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]      MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic            ID_INSTR = 1'b0;
  localparam logic            ID_DATA  = 1'b1;

  logic             lock_q;
  logic             lock_id_q;
  logic             rr_last_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [3:0]       count_q;
  logic             err_q;
  logic             fifo_id_q [MAX_OUTSTANDING];

  logic win_id;
  logic win_req;
  logic stall;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Winner selection: a locked master keeps the port, otherwise priority or round-robin
  always_comb begin
    win_id = ID_INSTR;
    if (lock_q) begin
      win_id = lock_id_q;
    end else if (data_req_i && !instr_req_i) begin
      win_id = ID_DATA;
    end else if (data_req_i && instr_req_i) begin
      win_id = DATA_PRIO ? ID_DATA : ~rr_last_q;
    end
  end

  // A full FIFO blocks new requests; rvalid only unblocks through count_q next cycle
  assign stall   = (count_q == MAX_CNT);
  assign win_req = (win_id == ID_DATA) ? data_req_i : instr_req_i;
  assign push    = slv_req_o & slv_gnt_i;
  assign pop     = slv_rvalid_i & (count_q != 4'd0);
  assign head_id = fifo_id_q[rd_ptr_q];

  // Forward the winner's request fields to the shared slave port
  always_comb begin
    slv_req_o   = win_req & ~stall;
    slv_addr_o  = (win_id == ID_DATA) ? data_addr_i  : instr_addr_i;
    slv_we_o    = (win_id == ID_DATA) ? data_we_i    : instr_we_i;
    slv_be_o    = (win_id == ID_DATA) ? data_be_i    : instr_be_i;
    slv_wdata_o = (win_id == ID_DATA) ? data_wdata_i : instr_wdata_i;
  end

  assign instr_gnt_o    = push & (win_id == ID_INSTR);
  assign data_gnt_o     = push & (win_id == ID_DATA);
  assign instr_rvalid_o = pop & (head_id == ID_INSTR);
  assign data_rvalid_o  = pop & (head_id == ID_DATA);
  assign instr_rdata_o  = slv_rdata_i;
  assign data_rdata_o   = slv_rdata_i;
  assign outstanding_o  = count_q;
  assign err_o          = err_q;

  // Arbitration state, FIFO pointers, occupancy and the sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_INSTR;
      rr_last_q <= ID_INSTR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      if (slv_req_o && !slv_gnt_i) begin
        lock_q    <= 1'b1;
        lock_id_q <= win_id;
      end else if (push) begin
        lock_q    <= 1'b0;
      end
      if (push) begin
        rr_last_q <= win_id;
        wr_ptr_q  <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      if (slv_rvalid_i && count_q == 4'd0) begin
        err_q <= 1'b1;
      end
    end
  end

  // ID storage: entries are only meaningful between the pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_id_q[wr_ptr_q] <= win_id;
    end
  end

endmodule

// File: tb/tb_cpu_obi_port_arbiter.sv
// Directed bench for cpu_obi_port_arbiter. Two instances share the same
// stimulus: u_prio uses fixed data priority, u_rr uses round-robin.
module tb_cpu_obi_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_be, d_be;
  logic        s_gnt, s_rvalid;
  logic [31:0] s_rdata;

  logic        p_instr_gnt, p_instr_rvalid, p_data_gnt, p_data_rvalid;
  logic [31:0] p_instr_rdata, p_data_rdata;
  logic        p_slv_req, p_slv_we;
  logic [31:0] p_slv_addr, p_slv_wdata;
  logic [3:0]  p_slv_be, p_outstanding;
  logic        p_err;

  logic        r_instr_gnt, r_instr_rvalid, r_data_gnt, r_data_rvalid;
  logic [31:0] r_instr_rdata, r_data_rdata;
  logic        r_slv_req, r_slv_we;
  logic [31:0] r_slv_addr, r_slv_wdata;
  logic [3:0]  r_slv_be, r_outstanding;
  logic        r_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_obi_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) u_prio (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_we_i(i_we), .instr_be_i(i_be),
    .instr_wdata_i(i_wdata), .instr_gnt_o(p_instr_gnt), .instr_rvalid_o(p_instr_rvalid),
    .instr_rdata_o(p_instr_rdata),
    .data_req_i(d_req), .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be),
    .data_wdata_i(d_wdata), .data_gnt_o(p_data_gnt), .data_rvalid_o(p_data_rvalid),
    .data_rdata_o(p_data_rdata),
    .slv_req_o(p_slv_req), .slv_addr_o(p_slv_addr), .slv_we_o(p_slv_we), .slv_be_o(p_slv_be),
    .slv_wdata_o(p_slv_wdata), .slv_gnt_i(s_gnt), .slv_rvalid_i(s_rvalid), .slv_rdata_i(s_rdata),
    .outstanding_o(p_outstanding), .err_o(p_err)
  );

  cpu_obi_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_we_i(i_we), .instr_be_i(i_be),
    .instr_wdata_i(i_wdata), .instr_gnt_o(r_instr_gnt), .instr_rvalid_o(r_instr_rvalid),
    .instr_rdata_o(r_instr_rdata),
    .data_req_i(d_req), .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be),
    .data_wdata_i(d_wdata), .data_gnt_o(r_data_gnt), .data_rvalid_o(r_data_rvalid),
    .data_rdata_o(r_data_rdata),
    .slv_req_o(r_slv_req), .slv_addr_o(r_slv_addr), .slv_we_o(r_slv_we), .slv_be_o(r_slv_be),
    .slv_wdata_o(r_slv_wdata), .slv_gnt_i(s_gnt), .slv_rvalid_i(s_rvalid), .slv_rdata_i(s_rdata),
    .outstanding_o(r_outstanding), .err_o(r_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    i_req = 1'b0; i_addr = '0; i_we = 1'b0; i_be = 4'hF; i_wdata = '0;
    d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h5A;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    check_eq("rst_outstanding", 32'(p_outstanding), 32'd0);
    check_eq("rst_err", 32'(p_err), 32'd0);
    check_eq("rst_slv_req", 32'(p_slv_req), 32'd0);
    check_eq("rst_gnt", 32'({p_instr_gnt, p_data_gnt}), 32'd0);
    check_eq("rst_rvalid", 32'({p_instr_rvalid, p_data_rvalid}), 32'd0);
    check_eq("rst_rdata_pass", p_instr_rdata, 32'h5A);
    check_eq("rst_rr_outstanding", 32'(r_outstanding), 32'd0);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: data-only transaction with one wait state on gnt
    d_req = 1'b1; d_addr = 32'h100; settle();
    check_eq("t1_slv_req", 32'(p_slv_req), 32'd1);
    check_eq("t1_slv_addr", p_slv_addr, 32'h100);
    check_eq("t1_no_gnt", 32'(p_data_gnt), 32'd0);
    step();
    s_gnt = 1'b1; settle();
    check_eq("t1_data_gnt", 32'(p_data_gnt), 32'd1);
    check_eq("t1_instr_gnt", 32'(p_instr_gnt), 32'd0);
    step();
    d_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE; settle();
    check_eq("t1_outstanding", 32'(p_outstanding), 32'd1);
    check_eq("t1_data_rvalid", 32'(p_data_rvalid), 32'd1);
    check_eq("t1_data_rdata", p_data_rdata, 32'hCAFE);
    check_eq("t1_instr_rvalid", 32'(p_instr_rvalid), 32'd0);
    step();
    s_rvalid = 1'b0; settle();
    check_eq("t1_drained", 32'(p_outstanding), 32'd0);

    // 2: round-robin with both masters requesting
    do_reset();
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300; s_gnt = 1'b1; settle();
    check_eq("t2_rr_addr0", r_slv_addr, 32'h300);
    check_eq("t2_rr_dgnt0", 32'(r_data_gnt), 32'd1);
    check_eq("t2_rr_ignt0", 32'(r_instr_gnt), 32'd0);
    step();
    d_addr = 32'h304; settle();
    check_eq("t2_rr_addr1", r_slv_addr, 32'h200);
    check_eq("t2_rr_ignt1", 32'(r_instr_gnt), 32'd1);
    check_eq("t2_rr_dgnt1", 32'(r_data_gnt), 32'd0);
    check_eq("t2_prio_addr1", p_slv_addr, 32'h304);
    step();
    i_req = 1'b0; d_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h11; settle();
    check_eq("t2_rr_outstanding", 32'(r_outstanding), 32'd2);
    check_eq("t2_rr_drv0", 32'(r_data_rvalid), 32'd1);
    check_eq("t2_rr_irv0", 32'(r_instr_rvalid), 32'd0);
    step();
    s_rdata = 32'h22; settle();
    check_eq("t2_rr_irv1", 32'(r_instr_rvalid), 32'd1);
    check_eq("t2_rr_drv1", 32'(r_data_rvalid), 32'd0);
    check_eq("t2_prio_drv1", 32'(p_data_rvalid), 32'd1);
    step();
    s_rvalid = 1'b0; settle();
    check_eq("t2_rr_drained", 32'(r_outstanding), 32'd0);

    // 4: stall at MAX_OUTSTANDING, released the cycle after rvalid
    do_reset();
    i_req = 1'b1; i_addr = 32'h600; s_gnt = 1'b1; step();
    i_addr = 32'h604; step();
    i_addr = 32'h608; settle();
    check_eq("t4_stall_req", 32'(p_slv_req), 32'd0);
    check_eq("t4_stall_gnt", 32'(p_instr_gnt), 32'd0);
    check_eq("t4_full", 32'(p_outstanding), 32'd2);
    s_rvalid = 1'b1; s_rdata = 32'h33; settle();
    check_eq("t4_same_cycle_req", 32'(p_slv_req), 32'd0);
    check_eq("t4_rvalid", 32'(p_instr_rvalid), 32'd1);
    step();
    s_rvalid = 1'b0; settle();
    check_eq("t4_reassert_req", 32'(p_slv_req), 32'd1);
    check_eq("t4_reassert_addr", p_slv_addr, 32'h608);
    check_eq("t4_count_after_pop", 32'(p_outstanding), 32'd1);
    step();

    // 3: fixed priority with gnt withheld, then lock against a late data request
    do_reset();
    i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h500; s_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("t3_wait_addr", p_slv_addr, 32'h500);
      check_eq("t3_wait_req", 32'(p_slv_req), 32'd1);
      check_eq("t3_wait_gnt", 32'(p_data_gnt), 32'd0);
      step();
    end
    s_gnt = 1'b1; settle();
    check_eq("t3_data_gnt", 32'(p_data_gnt), 32'd1);
    check_eq("t3_instr_gnt", 32'(p_instr_gnt), 32'd0);
    step();
    d_req = 1'b0; s_gnt = 1'b0; settle();
    check_eq("t3_instr_addr", p_slv_addr, 32'h400);
    step();
    d_req = 1'b1; d_addr = 32'h504; settle();
    check_eq("t3_locked_addr", p_slv_addr, 32'h400);
    check_eq("t3_locked_dgnt", 32'(p_data_gnt), 32'd0);
    step();
    s_gnt = 1'b1; settle();
    check_eq("t3_locked_ignt", 32'(p_instr_gnt), 32'd1);
    check_eq("t3_locked_dgnt2", 32'(p_data_gnt), 32'd0);
    step();

    // 6: reset mid-burst flushes the FIFO; late responses raise err_o
    i_req = 1'b0; d_req = 1'b0; s_gnt = 1'b0; settle();
    check_eq("t6_pre_reset_count", 32'(p_outstanding), 32'd2);
    rst_n = 1'b0; settle();
    check_eq("t6_async_flush", 32'(p_outstanding), 32'd0);
    step();
    rst_n = 1'b1; step();
    s_rvalid = 1'b1; s_rdata = 32'h77; settle();
    check_eq("t6_no_irvalid", 32'(p_instr_rvalid), 32'd0);
    check_eq("t6_no_drvalid", 32'(p_data_rvalid), 32'd0);
    step();
    s_rvalid = 1'b0; settle();
    check_eq("t6_err", 32'(p_err), 32'd1);
    check_eq("t6_count_zero", 32'(p_outstanding), 32'd0);
    step();
    check_eq("t6_err_sticky", 32'(p_err), 32'd1);
    do_reset();

    // 5: interleaved I, D, I with a push and pop in the same cycle
    i_req = 1'b1; i_addr = 32'h700; s_gnt = 1'b1; settle();
    check_eq("t5_ignt0", 32'(p_instr_gnt), 32'd1);
    step();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h800; settle();
    check_eq("t5_dgnt", 32'(p_data_gnt), 32'd1);
    step();
    d_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1; settle();
    check_eq("t5_irv1", 32'(p_instr_rvalid), 32'd1);
    check_eq("t5_drv1", 32'(p_data_rvalid), 32'd0);
    check_eq("t5_rdata1", p_instr_rdata, 32'h1);
    step();
    i_req = 1'b1; i_addr = 32'h704; s_gnt = 1'b1; s_rdata = 32'h2; settle();
    check_eq("t5_drv2", 32'(p_data_rvalid), 32'd1);
    check_eq("t5_irv2", 32'(p_instr_rvalid), 32'd0);
    check_eq("t5_ignt2", 32'(p_instr_gnt), 32'd1);
    step();
    i_req = 1'b0; s_gnt = 1'b0; s_rdata = 32'h3; settle();
    check_eq("t5_push_pop_count", 32'(p_outstanding), 32'd1);
    check_eq("t5_irv3", 32'(p_instr_rvalid), 32'd1);
    check_eq("t5_drv3", 32'(p_data_rvalid), 32'd0);
    step();
    s_rvalid = 1'b0; settle();
    check_eq("t5_drained", 32'(p_outstanding), 32'd0);
    check_eq("t5_no_err", 32'(p_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
